// File: rtl/ir_queue_env.sv
// DLX instruction register fed by a DEPTH-entry prefetch FIFO, with
// combinational field decode and selectable immediate extension.
module ir_queue_env #(
  parameter int         DEPTH      = 4,
  parameter logic [4:0] LINK_REG   = 5'd31,
  parameter bit         ZEXT_LOGIC = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [31:0]            DI,
  input  logic                   DI_VALID,
  output logic                   DI_READY,
  input  logic                   FLUSH,
  input  logic                   IRCE,
  input  logic                   JLINK,
  output logic [31:0]            IR_OUT,
  output logic                   IR_VALID,
  output logic [5:0]             IR_31_26,
  output logic [5:0]             IR_5_0,
  output logic [4:0]             RS1,
  output logic [4:0]             RS2,
  output logic [4:0]             RD,
  output logic [31:0]            imm,
  output logic [15:0]            SEXT,
  output logic [$clog2(DEPTH):0] COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          push_s, pop_s, is_logic_s;
  logic [4:0]    rd_s;

  // FLUSH blocks both queue operations; the offered word is simply dropped.
  assign DI_READY = (count_q != FULL_CNT);
  assign push_s   = DI_VALID & DI_READY & ~FLUSH;
  assign pop_s    = IRCE & (count_q != CNT_ZERO) & ~FLUSH;
  assign IR_OUT   = ir_q;
  assign IR_VALID = ir_valid_q;
  assign COUNT    = count_q;

  // Next-state for pointers, occupancy and the instruction register.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (FLUSH) begin
      wptr_d     = PTR_ZERO;
      rptr_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
      ir_d       = 32'h0000_0000;
      ir_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        ir_d       = mem_q[rptr_q];
        ir_valid_d = 1'b1;
        rptr_d     = rptr_q + PTR_ONE;
      end else if (IRCE) begin
        ir_valid_d = 1'b0;
      end else begin
        ir_valid_d = ir_valid_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Queue storage carries no reset; occupancy alone defines what is live.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wptr_q] <= DI;
    end
  end

  // ANDI/ORI/XORI are the only candidates for zero-extension.
  always_comb begin
    case (ir_q[31:26])
      6'h0C, 6'h0D, 6'h0E: is_logic_s = 1'b1;
      default:             is_logic_s = 1'b0;
    endcase
  end

  // Field decode; driven regardless of IR_VALID.
  always_comb begin
    IR_31_26 = ir_q[31:26];
    RS1      = ir_q[25:21];
    RS2      = ir_q[20:16];
    if (ir_q[31:26] == 6'h00) begin
      rd_s   = ir_q[15:11];
      IR_5_0 = ir_q[5:0];
      imm    = 32'h0000_0000;
    end else begin
      rd_s   = ir_q[20:16];
      IR_5_0 = 6'h00;
      if (ZEXT_LOGIC && is_logic_s) begin
        imm = {16'h0000, ir_q[15:0]};
      end else begin
        imm = {{16{ir_q[15]}}, ir_q[15:0]};
      end
    end
    if (JLINK) begin
      RD = LINK_REG;
    end else begin
      RD = rd_s;
    end
    if (imm[15]) begin
      SEXT = imm[15:0];
    end else begin
      SEXT = 16'h0000;
    end
  end

endmodule

// File: tb/tb_ir_queue_env.sv
// Directed bench for ir_queue_env: one sign-extending and one zero-extending
// instance share all inputs.
module tb_ir_queue_env;
  logic        CLK = 1'b0;
  logic        RESET_N, DI_VALID, FLUSH, IRCE, JLINK;
  logic [31:0] DI;
  logic        DI_READY, IR_VALID, z_ready, z_valid;
  logic [31:0] IR_OUT, imm, z_ir, z_imm;
  logic [5:0]  IR_31_26, IR_5_0, z_op, z_fn;
  logic [4:0]  RS1, RS2, RD, z_rs1, z_rs2, z_rd;
  logic [15:0] SEXT, z_sext;
  logic [2:0]  COUNT, z_count;
  int tests_run = 0;
  int tests_failed = 0;

  ir_queue_env #(.DEPTH(4), .LINK_REG(5'd31), .ZEXT_LOGIC(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DI(DI), .DI_VALID(DI_VALID), .DI_READY(DI_READY),
    .FLUSH(FLUSH), .IRCE(IRCE), .JLINK(JLINK), .IR_OUT(IR_OUT), .IR_VALID(IR_VALID),
    .IR_31_26(IR_31_26), .IR_5_0(IR_5_0), .RS1(RS1), .RS2(RS2), .RD(RD),
    .imm(imm), .SEXT(SEXT), .COUNT(COUNT));

  ir_queue_env #(.DEPTH(4), .LINK_REG(5'd31), .ZEXT_LOGIC(1'b1)) dut_z (
    .CLK(CLK), .RESET_N(RESET_N), .DI(DI), .DI_VALID(DI_VALID), .DI_READY(z_ready),
    .FLUSH(FLUSH), .IRCE(IRCE), .JLINK(JLINK), .IR_OUT(z_ir), .IR_VALID(z_valid),
    .IR_31_26(z_op), .IR_5_0(z_fn), .RS1(z_rs1), .RS2(z_rs2), .RD(z_rd),
    .imm(z_imm), .SEXT(z_sext), .COUNT(z_count));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    DI = w; DI_VALID = 1'b1; tick(); DI_VALID = 1'b0;
  endtask

  task automatic load_ir();
    IRCE = 1'b1; tick(); IRCE = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++; if (IR_OUT !== 32'h0) begin tests_failed++; $display("FAIL reset_ir got=%h exp=%h", IR_OUT, 32'h0); end
    tests_run++; if (IR_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", IR_VALID); end
    tests_run++; if (COUNT !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    tests_run++; if (DI_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", DI_READY); end
    tests_run++; if ({RD, IR_5_0, imm, SEXT} !== 59'h0) begin tests_failed++; $display("FAIL reset_decode rd=%0d fn=%h imm=%h sext=%h exp all 0", RD, IR_5_0, imm, SEXT); end
    JLINK = 1'b1; #1;
    tests_run++; if (RD !== 5'd31) begin tests_failed++; $display("FAIL reset_jlink_rd got=%0d exp=31", RD); end
    JLINK = 1'b0;
    @(posedge CLK); #1; RESET_N = 1'b1;
  endtask

  task automatic test_addi();
    push_word(32'h2001_0005);
    tests_run++; if (COUNT !== 3'd1) begin tests_failed++; $display("FAIL addi_count_push got=%0d exp=1", COUNT); end
    load_ir();
    tests_run++; if (IR_OUT !== 32'h2001_0005 || IR_VALID !== 1'b1) begin tests_failed++; $display("FAIL addi_ir got=%h/%b exp=20010005/1", IR_OUT, IR_VALID); end
    tests_run++; if (IR_31_26 !== 6'h08 || RS1 !== 5'd0 || RD !== 5'd1) begin tests_failed++; $display("FAIL addi_fields op=%h rs1=%0d rd=%0d exp=08/0/1", IR_31_26, RS1, RD); end
    tests_run++; if (imm !== 32'h5 || IR_5_0 !== 6'h0 || SEXT !== 16'h0) begin tests_failed++; $display("FAIL addi_imm imm=%h fn=%h sext=%h exp=5/0/0", imm, IR_5_0, SEXT); end
    tests_run++; if (COUNT !== 3'd0) begin tests_failed++; $display("FAIL addi_count got=%0d exp=0", COUNT); end
  endtask

  task automatic test_rtype();
    push_word(32'h0022_1820);
    load_ir();
    tests_run++; if (RS1 !== 5'd1 || RS2 !== 5'd2 || RD !== 5'd3) begin tests_failed++; $display("FAIL rtype_regs rs1=%0d rs2=%0d rd=%0d exp=1/2/3", RS1, RS2, RD); end
    tests_run++; if (IR_5_0 !== 6'h20 || imm !== 32'h0) begin tests_failed++; $display("FAIL rtype_fn fn=%h imm=%h exp=20/0", IR_5_0, imm); end
    JLINK = 1'b1; #1;
    tests_run++; if (RD !== 5'd31) begin tests_failed++; $display("FAIL rtype_jlink got=%0d exp=31", RD); end
    JLINK = 1'b0;
  endtask

  task automatic test_zext();
    push_word(32'h3421_FFFF);
    load_ir();
    tests_run++; if (z_imm !== 32'h0000_FFFF || z_sext !== 16'hFFFF) begin tests_failed++; $display("FAIL ori_zext imm=%h sext=%h exp=0000ffff/ffff", z_imm, z_sext); end
    tests_run++; if (imm !== 32'hFFFF_FFFF || SEXT !== 16'hFFFF) begin tests_failed++; $display("FAIL ori_sext imm=%h sext=%h exp=ffffffff/ffff", imm, SEXT); end
    tests_run++; if (RD !== 5'd1 || z_rd !== 5'd1) begin tests_failed++; $display("FAIL ori_rd got=%0d/%0d exp=1", RD, z_rd); end
    push_word(32'h2001_8000);
    load_ir();
    tests_run++; if (z_imm !== 32'hFFFF_8000 || imm !== 32'hFFFF_8000 || SEXT !== 16'h8000) begin tests_failed++; $display("FAIL addi_neg z_imm=%h imm=%h sext=%h exp=ffff8000/ffff8000/8000", z_imm, imm, SEXT); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] w [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    logic [2:0]  exp_cnt [6] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic        exp_v   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_ir  [6] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 32'h5555_5555};
    for (int i = 0; i < 5; i++) begin
      DI = w[i]; DI_VALID = 1'b1; tick();
      tests_run++; if (COUNT !== ((i < 3) ? 3'(i + 1) : 3'd4) || DI_READY !== (i < 3)) begin tests_failed++; $display("FAIL fill_%0d count=%0d ready=%b", i, COUNT, DI_READY); end
    end
    IRCE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DI_VALID = (i < 2); DI = w[4]; tick();
      tests_run++; if (IR_OUT !== exp_ir[i] || IR_VALID !== exp_v[i] || COUNT !== exp_cnt[i]) begin tests_failed++; $display("FAIL drain_%0d ir=%h v=%b cnt=%0d exp=%h/%b/%0d", i, IR_OUT, IR_VALID, COUNT, exp_ir[i], exp_v[i], exp_cnt[i]); end
    end
    IRCE = 1'b0; DI_VALID = 1'b0;
  endtask

  task automatic test_back_to_back_flush();
    push_word(32'hA000_0001);
    push_word(32'hA000_0002);
    push_word(32'hA000_0003);
    DI = 32'hA000_0004; DI_VALID = 1'b1; IRCE = 1'b1; tick();
    tests_run++; if (COUNT !== 3'd3 || IR_OUT !== 32'hA000_0001 || IR_VALID !== 1'b1) begin tests_failed++; $display("FAIL push_pop cnt=%0d ir=%h v=%b exp=3/a0000001/1", COUNT, IR_OUT, IR_VALID); end
    DI = 32'hA000_0005; FLUSH = 1'b1; tick();
    FLUSH = 1'b0; DI_VALID = 1'b0;
    tests_run++; if (COUNT !== 3'd0 || IR_VALID !== 1'b0 || IR_OUT !== 32'h0 || DI_READY !== 1'b1) begin tests_failed++; $display("FAIL flush cnt=%0d v=%b ir=%h rdy=%b exp=0/0/0/1", COUNT, IR_VALID, IR_OUT, DI_READY); end
    tick();
    IRCE = 1'b0;
    tests_run++; if (IR_VALID !== 1'b0 || COUNT !== 3'd0) begin tests_failed++; $display("FAIL flush_dropped v=%b cnt=%0d exp=0/0", IR_VALID, COUNT); end
  endtask

  task automatic test_async_reset();
    push_word(32'hB000_0001);
    push_word(32'hB000_0002);
    push_word(32'hB000_0003);
    load_ir();
    tests_run++; if (COUNT !== 3'd2 || IR_VALID !== 1'b1) begin tests_failed++; $display("FAIL pre_reset cnt=%0d v=%b exp=2/1", COUNT, IR_VALID); end
    #2; RESET_N = 1'b0; #1;
    tests_run++; if (COUNT !== 3'd0 || IR_VALID !== 1'b0 || IR_OUT !== 32'h0 || DI_READY !== 1'b1) begin tests_failed++; $display("FAIL async_reset cnt=%0d v=%b ir=%h rdy=%b exp=0/0/0/1", COUNT, IR_VALID, IR_OUT, DI_READY); end
    #2; RESET_N = 1'b1;
    load_ir();
    tests_run++; if (IR_VALID !== 1'b0 || COUNT !== 3'd0) begin tests_failed++; $display("FAIL post_reset_irce v=%b cnt=%0d exp=0/0", IR_VALID, COUNT); end
    push_word(32'hC000_00C3);
    tests_run++; if (COUNT !== 3'd1) begin tests_failed++; $display("FAIL post_reset_push cnt=%0d exp=1", COUNT); end
    load_ir();
    tests_run++; if (IR_OUT !== 32'hC000_00C3 || IR_VALID !== 1'b1) begin tests_failed++; $display("FAIL post_reset_load ir=%h v=%b exp=c00000c3/1", IR_OUT, IR_VALID); end
  endtask

  initial begin
    RESET_N = 1'b0; DI = 32'h0; DI_VALID = 1'b0; FLUSH = 1'b0; IRCE = 1'b0; JLINK = 1'b0;
    test_reset();
    test_addi();
    test_rtype();
    test_zext();
    test_full_wrap();
    test_back_to_back_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ir_queue_env.md
# ir_queue_env

Instruction-register environment with an integrated prefetch queue for the DLX core. Fetched instruction words are buffered in a DEPTH-entry FIFO. The head word is loaded into the instruction register on IRCE. The registered instruction is decoded into opcode, function, register specifiers and an extended immediate. This block sits between the memory/IO fetch path and the control/register-file stage. It adds decoupled fetch, flush and selectable zero-extension for logical immediates.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- LINK_REG, 5'd31: destination forced onto RD when JLINK=1.
- ZEXT_LOGIC, 0: 1 = ANDI/ORI/XORI (opcodes 6'h0C/6'h0D/6'h0E) zero-extend imm; 0 = all I-type sign-extend.

- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DI  in  32  fetched instruction word.
- DI_VALID  in  1  DI holds a word to enqueue.
- DI_READY  out  1  queue not full; push occurs when DI_VALID & DI_READY.
- FLUSH  in  1  discard queue contents and invalidate IR.
- IRCE  in  1  load queue head into IR.
- JLINK  in  1  force RD = LINK_REG (combinational).
- IR_OUT  out  32  instruction register.
- IR_VALID  out  1  IR_OUT holds a live instruction.
- IR_31_26  out  6  opcode.
- IR_5_0  out  6  function field; 0 for non-R-type.
- RS1, RS2, RD  out  5 each  register specifiers.
- imm  out  32  extended immediate; 0 for R-type.
- SEXT  out  16  imm[15:0] when imm[15]=1, else 0.
- COUNT  out  clog2(DEPTH)+1  queue occupancy.

## Operation
- Queue: circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter. DI_READY = (COUNT != DEPTH), combinational from the counter.
- Push: DI_VALID & DI_READY writes DI at wptr, then wptr+1 and COUNT+1.
- IRCE with COUNT>0: IR_OUT ← head word, rptr+1, COUNT−1, IR_VALID ← 1.
- IRCE with COUNT=0: IR_OUT holds, IR_VALID ← 0. There is no bypass from DI.
- No IRCE: IR_OUT and IR_VALID hold.
- Push and pop in the same cycle: both occur and COUNT is unchanged. This cannot occur when full, because DI_READY=0.
- FLUSH has the highest priority. Pointers and COUNT clear to 0, IR_OUT ← 0, IR_VALID ← 0. A same-cycle push or IRCE is ignored. DI_READY may be 1 during FLUSH, but the offered word is dropped; the producer must re-present it.
- Decode is purely combinational from IR_OUT:
  - IR_31_26 = IR_OUT[31:26]; RS1 = IR_OUT[25:21]; RS2 = IR_OUT[20:16].
  - R-type (opcode 0): RD = IR_OUT[15:11], IR_5_0 = IR_OUT[5:0], imm = 0.
  - Otherwise: RD = IR_OUT[20:16], IR_5_0 = 0, imm = {16{IR_OUT[15]}, IR_OUT[15:0]}. When ZEXT_LOGIC=1 and the opcode is 0C/0D/0E, the upper half of imm is 0 instead.
  - RD = LINK_REG whenever JLINK=1, regardless of instruction type.
  - SEXT = imm[15] ? imm[15:0] : 16'h0.
- Decode outputs are driven even when IR_VALID=0. Consumers qualify them with IR_VALID.

## Timing
- Reset (RESET_N=0, asynchronous, effective immediately):
  - IR_OUT=0, IR_VALID=0, COUNT=0, pointers=0.
  - DI_READY=1.
  - Decode of IR_OUT=0: RD=0 (or LINK_REG if JLINK=1), imm=0, SEXT=0, IR_5_0=0.
- Queue storage is not reset; only the pointers and counter are.
- Reset asserted mid-operation discards all queued words. The first push after release is accepted on the first rising edge with RESET_N=1.
- Latency: a word pushed at edge k is available as head after edge k. IRCE at edge k+1 gives IR_OUT at edge k+1, so the minimum DI→IR latency is 1 cycle.
- Throughput: one push and one IR load per cycle in steady state.
- Full boundary: after the DEPTH-th push with no pop, DI_READY=0 in the next cycle. A pop in that cycle raises DI_READY in the following cycle.
- Wrap-around: the pointer at DEPTH−1 increments to 0. FIFO order is preserved across wraps.

## Test plan
- Reset, then push 32'h20010005 (ADDI r1,r0,5), then IRCE → IR_VALID=1, RS1=0, RD=1, imm=32'h00000005, IR_5_0=0, COUNT=0.
- Push R-type 32'h00221820 (ADD r3,r1,r2), then IRCE with JLINK=0 → RD=3, IR_5_0=6'h20, imm=0. Then drive JLINK=1 → RD=31.
- With ZEXT_LOGIC=1, push ORI 32'h3421FFFF, then IRCE → imm=32'h0000FFFF, SEXT=16'hFFFF. With ZEXT_LOGIC=0, the same word → imm=32'hFFFFFFFF.
- DEPTH=4:
  - Push 5 words back-to-back → DI_READY=0 after the 4th push, 5th word not accepted, COUNT=4.
  - Then 6 cycles of IRCE with the 5th word re-presented → IR_OUT sequences words 1–5 in order, wrapping the pointers.
  - IR_VALID=0 after the queue drains.
- Fill 3 words, then assert FLUSH together with IRCE and DI_VALID → next cycle COUNT=0, IR_VALID=0, IR_OUT=0, pushed word dropped.
- Assert RESET_N=0 asynchronously mid-stream with COUNT=2 → outputs clear without a clock edge. After release, IRCE with no push gives IR_VALID=0.
